// File: rtl/td_mon_pkg.sv
// Shared types and constants for the tap-delay monitor: FSM states,
// error codes and the number of delay-line taps.
package td_mon_pkg;

    localparam int NUM_TAPS = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ORDER   = 2'd2;
    localparam logic [1:0] ERR_RETRIG  = 2'd3;

endpackage

// File: rtl/td_sync.sv
// Two-flop synchronizer with a configurable width and reset value, used
// to bring the asynchronous trigger and tap inputs into the clk domain.
module td_sync #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/td_tap_monitor.sv
// Measures trigger-to-tap delays of a five-tap delay line in clk cycles.
// Define TD_MON_GLITCH_FILTER_EN to require two low samples per tap fall.
module td_tap_monitor
    import td_mon_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 63
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      trig,
    input  logic [NUM_TAPS-1:0]       tap_n,
    output logic [NUM_TAPS*CNT_W-1:0] delay,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t                    state, state_next;
    logic                      trig_s, trig_p, trig_rise;
    logic [NUM_TAPS-1:0]       tap_s, tap_p, tap_fall;
    logic [CNT_W-1:0]          count, count_next, cnt_now, cap_val;
    logic [NUM_TAPS-1:0]       captured, captured_next, cap_mask;
    logic [NUM_TAPS*CNT_W-1:0] delay_q, delay_next;
    logic [1:0]                code_q, code_next;
    logic                      done_q, done_next, err_q, err_next;
    logic                      order_bad;

    td_sync #(.W(1), .RST_VAL(1'b0)) u_sync_trig (
        .clk   (clk),
        .reset (reset),
        .d     (trig),
        .q     (trig_s)
    );

    td_sync #(.W(NUM_TAPS), .RST_VAL({NUM_TAPS{1'b1}})) u_sync_tap (
        .clk   (clk),
        .reset (reset),
        .d     (tap_n),
        .q     (tap_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_p <= 1'b0;
            tap_p  <= '1;
        end else begin
            trig_p <= trig_s;
            tap_p  <= tap_s;
        end
    end

    assign trig_rise = trig_s & ~trig_p;
    assign cnt_now   = (count == CNT_MAX) ? count : count + 1'b1;

`ifdef TD_MON_GLITCH_FILTER_EN
    logic [NUM_TAPS-1:0] tap_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            tap_p2 <= '1;
        end else begin
            tap_p2 <= tap_p;
        end
    end

    // Fall is confirmed one cycle late, so record the count of the first low sample.
    assign tap_fall = ~tap_s & ~tap_p & tap_p2;
    assign cap_val  = count;
`else
    assign tap_fall = ~tap_s & tap_p;
    assign cap_val  = cnt_now;
`endif

    // A tap may fall only once, and only after (or with) every lower tap.
    always_comb begin
        logic prefix_ok;
        order_bad = 1'b0;
        prefix_ok = 1'b1;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (tap_fall[k] && (captured[k] || !prefix_ok)) begin
                order_bad = 1'b1;
            end
            prefix_ok = prefix_ok & (captured[k] | tap_fall[k]);
        end
    end

    assign cap_mask = captured | tap_fall;

    always_comb begin
        state_next    = state;
        count_next    = count;
        captured_next = captured;
        delay_next    = delay_q;
        code_next     = code_q;
        done_next     = 1'b0;
        err_next      = 1'b0;
        case (state)
            IDLE: begin
                if (trig_rise) begin
                    count_next    = '0;
                    captured_next = '0;
                    delay_next    = '0;
                    code_next     = ERR_NONE;
                    state_next    = ARMED;
                end
            end
            ARMED: begin
                count_next = cnt_now;
                if (trig_rise) begin
                    err_next   = 1'b1;
                    code_next  = ERR_RETRIG;
                    state_next = IDLE;
                end else if (order_bad) begin
                    err_next   = 1'b1;
                    code_next  = ERR_ORDER;
                    state_next = IDLE;
                end else begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        if (tap_fall[k]) begin
                            delay_next[k*CNT_W +: CNT_W] = cap_val;
                        end
                    end
                    captured_next = cap_mask;
                    if (&cap_mask) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else if (cnt_now >= TIMEOUT_CNT) begin
                        err_next   = 1'b1;
                        code_next  = ERR_TIMEOUT;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            captured <= '0;
            delay_q  <= '0;
            code_q   <= ERR_NONE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            captured <= captured_next;
            delay_q  <= delay_next;
            code_q   <= code_next;
            done_q   <= done_next;
            err_q    <= err_next;
        end
    end

    assign delay    = delay_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign busy     = (state == ARMED);

endmodule

// File: tb/tb_td_tap_monitor.sv
// Directed self-checking bench for td_tap_monitor: nominal, timeout, order,
// retrigger, simultaneous, reset-abort and glitch scenarios.
module tb_td_tap_monitor;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 63;

    logic               clk = 1'b0;
    logic               reset;
    logic               trig;
    logic [4:0]         tap_n;
    logic [5*CNT_W-1:0] delay;
    logic               done;
    logic               err;
    logic [1:0]         err_code;
    logic               busy;

    int errors = 0;
    int checks = 0;

    int done_cnt, err_cnt, both_cnt, done_at, err_at;
    logic busy_mid;

    always #5 clk = ~clk;

    td_tap_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .trig     (trig),
        .tap_n    (tap_n),
        .delay    (delay),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .busy     (busy)
    );

    function automatic logic [5*CNT_W-1:0] pack5(input int d4, input int d3, input int d2,
                                                  input int d1, input int d0);
        return {CNT_W'(d4), CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    endfunction

    // Trigger at cycle 0, then apply scheduled tap falls / glitch / retrigger / reset.
    task automatic drive_run(input int t0, input int t1, input int t2, input int t3,
                             input int t4, input int glitch_cyc, input int retrig_cyc,
                             input int reset_cyc, input int ncyc);
        int tc[5];
        tc = '{t0, t1, t2, t3, t4};
        done_cnt = 0; err_cnt = 0; both_cnt = 0; done_at = -1; err_at = -1; busy_mid = 1'b0;
        @(posedge clk); #1;
        trig = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            if (done) begin done_cnt++; if (done_at < 0) done_at = c; end
            if (err) begin err_cnt++; if (err_at < 0) err_at = c; end
            if (done && err) both_cnt++;
            if (c == 10) busy_mid = busy;
            for (int k = 0; k < 5; k++) if (tc[k] == c) tap_n[k] = 1'b0;
            if (glitch_cyc > 0 && c == glitch_cyc) tap_n[0] = 1'b0;
            if (glitch_cyc > 0 && c == glitch_cyc + 1) tap_n[0] = 1'b1;
            if (retrig_cyc > 0 && c == retrig_cyc - 4) trig = 1'b0;
            if (retrig_cyc > 0 && c == retrig_cyc) trig = 1'b1;
            if (reset_cyc > 0 && c == reset_cyc) begin reset = 1'b1; trig = 1'b0; end
            if (reset_cyc > 0 && c == reset_cyc + 1) reset = 1'b0;
        end
        trig  = 1'b0;
        tap_n = '1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; trig = 1'b0; tap_n = '1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (delay !== '0) begin errors++; $display("[TB] FAIL reset_delay got=%h exp=0", delay); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("[TB] FAIL reset_code got=%0d exp=0", err_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_nominal();
        int exp_done_at;
`ifdef TD_MON_GLITCH_FILTER_EN
        exp_done_at = 29;
`else
        exp_done_at = 28;
`endif
        drive_run(5, 10, 15, 20, 25, -1, -1, -1, 40);
        checks++; if (delay !== pack5(25, 20, 15, 10, 5)) begin errors++; $display("[TB] FAIL nom_delay got=%h exp=%h", delay, pack5(25, 20, 15, 10, 5)); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL nom_done_cnt got=%0d exp=1", done_cnt); end
        checks++; if (err_cnt != 0) begin errors++; $display("[TB] FAIL nom_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("[TB] FAIL nom_code got=%0d exp=0", err_code); end
        checks++; if (done_at != exp_done_at) begin errors++; $display("[TB] FAIL nom_done_at got=%0d exp=%0d", done_at, exp_done_at); end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("[TB] FAIL nom_busy_mid got=%b exp=1", busy_mid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nom_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_timeout();
        drive_run(5, 10, 15, 20, -1, -1, -1, -1, 80);
        checks++; if (delay !== pack5(0, 20, 15, 10, 5)) begin errors++; $display("[TB] FAIL to_delay got=%h exp=%h", delay, pack5(0, 20, 15, 10, 5)); end
        checks++; if (err_cnt != 1) begin errors++; $display("[TB] FAIL to_err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL to_done_cnt got=%0d exp=0", done_cnt); end
        checks++; if (err_code !== 2'd1) begin errors++; $display("[TB] FAIL to_code got=%0d exp=1", err_code); end
        checks++; if (err_at != 66) begin errors++; $display("[TB] FAIL to_err_at got=%0d exp=66", err_at); end
    endtask

    task automatic test_order();
        drive_run(4, 12, 8, -1, -1, -1, -1, -1, 30);
        checks++; if (err_cnt != 1) begin errors++; $display("[TB] FAIL ord_err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (err_code !== 2'd2) begin errors++; $display("[TB] FAIL ord_code got=%0d exp=2", err_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ord_busy got=%b exp=0", busy); end
        checks++; if (delay !== pack5(0, 0, 0, 0, 4)) begin errors++; $display("[TB] FAIL ord_delay got=%h exp=%h", delay, pack5(0, 0, 0, 0, 4)); end
        checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL ord_done_cnt got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_retrigger();
        drive_run(5, 10, 15, 20, 25, -1, 12, -1, 40);
        checks++; if (err_code !== 2'd3) begin errors++; $display("[TB] FAIL rt_code got=%0d exp=3", err_code); end
        checks++; if (err_cnt != 1) begin errors++; $display("[TB] FAIL rt_err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL rt_done_cnt got=%0d exp=0", done_cnt); end
        checks++; if (delay !== pack5(0, 0, 0, 10, 5)) begin errors++; $display("[TB] FAIL rt_delay got=%h exp=%h", delay, pack5(0, 0, 0, 10, 5)); end
        drive_run(6, 8, 12, 14, 30, -1, -1, -1, 40);
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL rt_clean_done got=%0d exp=1", done_cnt); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("[TB] FAIL rt_clean_code got=%0d exp=0", err_code); end
        checks++; if (delay !== pack5(30, 14, 12, 8, 6)) begin errors++; $display("[TB] FAIL rt_clean_delay got=%h exp=%h", delay, pack5(30, 14, 12, 8, 6)); end
    endtask

    task automatic test_back_to_back();
        drive_run(7, 7, 9, 11, 13, -1, -1, -1, 30);
        checks++; if (delay !== pack5(13, 11, 9, 7, 7)) begin errors++; $display("[TB] FAIL sim_delay got=%h exp=%h", delay, pack5(13, 11, 9, 7, 7)); end
        checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("[TB] FAIL sim_pulses done=%0d err=%0d exp done=1 err=0", done_cnt, err_cnt); end
        checks++; if (both_cnt != 0) begin errors++; $display("[TB] FAIL sim_both got=%0d exp=0", both_cnt); end
    endtask

    task automatic test_reset_abort();
        drive_run(5, 10, 15, 20, 25, -1, -1, 9, 40);
        checks++; if (delay !== '0) begin errors++; $display("[TB] FAIL rst_delay got=%h exp=0", delay); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("[TB] FAIL rst_code got=%0d exp=0", err_code); end
        checks++; if (done_cnt != 0 || err_cnt != 0) begin errors++; $display("[TB] FAIL rst_pulses done=%0d err=%0d exp 0 0", done_cnt, err_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_glitch();
        drive_run(5, 10, 15, 20, 25, 3, -1, -1, 40);
`ifdef TD_MON_GLITCH_FILTER_EN
        checks++; if (delay !== pack5(25, 20, 15, 10, 5)) begin errors++; $display("[TB] FAIL gl_delay got=%h exp=%h", delay, pack5(25, 20, 15, 10, 5)); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("[TB] FAIL gl_code got=%0d exp=0", err_code); end
        checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("[TB] FAIL gl_pulses done=%0d err=%0d exp done=1 err=0", done_cnt, err_cnt); end
`else
        checks++; if (delay !== pack5(0, 0, 0, 0, 3)) begin errors++; $display("[TB] FAIL gl_delay got=%h exp=%h", delay, pack5(0, 0, 0, 0, 3)); end
        checks++; if (err_code !== 2'd2) begin errors++; $display("[TB] FAIL gl_code got=%0d exp=2", err_code); end
        checks++; if (done_cnt != 0 || err_cnt != 1) begin errors++; $display("[TB] FAIL gl_pulses done=%0d err=%0d exp done=0 err=1", done_cnt, err_cnt); end
`endif
    endtask

    initial begin
        $display("[TB] td_tap_monitor directed test start");
        test_reset();
        test_nominal();
        test_timeout();
        test_order();
        test_retrigger();
        test_back_to_back();
        test_reset_abort();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/td_tap_monitor.md
TD_TAP_MONITOR -- requirements
Module: td_tap_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each delay counter/result.
REQ-002 SHALL have parameter TIMEOUT, default 63, max cycles from trigger to last tap before error; TIMEOUT < 2**CNT_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port trig  input  1  asynchronous delay-line trigger input; rising edge starts a measurement.
REQ-006 SHALL have port tap_n  input  5  asynchronous active-low tap pulses; bit 0 is the 50 ns tap, bit 4 is the 250 ns tap.
REQ-007 SHALL have port delay  output  5*CNT_W  captured cycle count per tap; tap k occupies bits [k*CNT_W +: CNT_W].
REQ-008 SHALL have port done  output  1  one-cycle pulse when all five taps are captured in order.
REQ-009 SHALL have port err  output  1  one-cycle pulse on any failure.
REQ-010 SHALL have port err_code  output  2  last failure: 0 none, 1 timeout, 2 order, 3 retrigger; held until next trigger.
REQ-011 SHALL have port busy  output  1  high while state is ARMED.

Function
REQ-012 SHALL pass trig and tap_n through 2-flop synchronizers, so all detection sees both signals with equal latency.
REQ-013 SHALL detect a trig rising edge and tap falling edges from synchronized current vs. previous samples.
REQ-014 SHALL implement states IDLE and ARMED.
REQ-015 In IDLE, a trig rising edge SHALL clear the counter, captured mask, delay and err_code, then enter ARMED on the next cycle.
REQ-016 In ARMED, the counter SHALL increment by 1 each cycle and saturate at 2**CNT_W-1.
REQ-017 A tap k falling edge SHALL load delay[k] with the counter value in that cycle and set captured bit k.
REQ-018 Tap k SHALL be accepted only if taps 0..k-1 are already captured or fall in the same cycle; same-cycle falls get identical counts.
REQ-019 An out-of-order fall, or a second fall on an already captured tap, SHALL pulse err, set err_code=2 and return to IDLE.
REQ-020 When all five taps are captured, the module SHALL pulse done in the following cycle and return to IDLE.
REQ-021 If the counter reaches TIMEOUT with any tap uncaptured, the module SHALL pulse err, set err_code=1 and return to IDLE; partial delay values are retained.
REQ-022 A trig rising edge in ARMED SHALL pulse err, set err_code=3 and return to IDLE; it SHALL NOT start a new measurement.
REQ-023 Tap falls in IDLE SHALL be ignored.
REQ-024 done and err SHALL never be high in the same cycle; failure wins over completion when both occur in the same cycle.

Reset
REQ-025 Reset SHALL force IDLE, counter=0, delay=0, captured=0, done=0, err=0, err_code=0, busy=0.
REQ-026 Reset SHALL preset the trig synchronizer to 0 and the tap synchronizers to all-ones (idle high), so no edge is detected after reset is released.
REQ-027 Reset during ARMED SHALL abandon the measurement silently, with no err or done pulse.

Configuration
REQ-028 The macro TD_MON_GLITCH_FILTER_EN SHALL control tap glitch filtering.
REQ-029 With TD_MON_GLITCH_FILTER_EN defined, a tap fall SHALL count only when the synchronized tap is low for 2 consecutive samples; capture then occurs one cycle later, and the recorded count is the first low sample minus nothing extra (count from the first low sample).
REQ-030 Without TD_MON_GLITCH_FILTER_EN, a single low synchronized sample after a high sample SHALL constitute a fall.

Structure
REQ-031 The package td_mon_pkg SHALL hold the state enum, the err_code constants and the tap count (5).
REQ-032 The 2-flop synchronizer SHALL be a sub-module td_sync, with a parameter for width and reset value, instantiated for trig and for tap_n.

Verification (clk period 10 ns)
REQ-033 Nominal: trig rises; taps fall 5, 10, 15, 20, 25 cycles later -> delay = {25, 20, 15, 10, 5} (tap4..tap0), one done pulse, err_code = 0.
REQ-034 Timeout: tap4 never falls -> err pulse at count 63, err_code = 1, delay[4] = 0, others retained.
REQ-035 Order: tap2 falls at cycle 8 before tap1 -> err pulse, err_code = 2, state IDLE.
REQ-036 Retrigger: second trig rise at cycle 12 -> err_code = 3, no done; the next trig rise runs a clean measurement.
REQ-037 Simultaneous and reset: tap0 and tap1 fall at cycle 7 -> both delays = 7; a separate run with reset at cycle 9 -> all outputs 0 and no pulses.
REQ-038 Glitch (macro defined): 1-cycle low on tap0 at cycle 3, real fall at cycle 5 -> delay[0] = 5; with the macro undefined, the same stimulus -> delay[0] = 3 and the fall at cycle 5 gives err_code = 2.
